// File: rtl/rd_stage_tracker.sv
// Destination-register tracker for EX/MEM/WB forwarding tags, with load-use stall detection.
// Optional saturating stall counter enabled by defining RD_TRACKER_STALL_COUNT_EN.
module rd_stage_tracker #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              flush_ex,
    output logic [REG_AW-1:0] rd_EX,
    output logic [REG_AW-1:0] rd_MEM,
    output logic [REG_AW-1:0] rd_WB,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic [CNT_W-1:0]  stall_count
);

    // EX stage state (p0); mem_read matters only while the load sits in EX
    logic              vld_p0;
    logic              wr_p0;
    logic              ld_p0;
    logic [REG_AW-1:0] rd_p0;
    // MEM stage state (p1)
    logic              vld_p1;
    logic              wr_p1;
    logic [REG_AW-1:0] rd_p1;
    // WB stage state (p2)
    logic              vld_p2;
    logic              wr_p2;
    logic [REG_AW-1:0] rd_p2;

    logic load_use;
    logic hit_rs1;
    logic hit_rs2;

    function automatic logic [REG_AW-1:0] tag(input logic vld, input logic wr,
                                              input logic [REG_AW-1:0] rd);
        return (vld && wr && (rd != '0)) ? rd : '0;
    endfunction

    always_comb begin
        hit_rs1  = id_uses_rs1 && (id_rs1 == rd_p0);
        hit_rs2  = id_uses_rs2 && (id_rs2 == rd_p0);
        load_use = id_valid && vld_p0 && ld_p0 && wr_p0 && (rd_p0 != '0)
                   && (hit_rs1 || hit_rs2);
    end

    // A redirect kills the ID instruction, so it must not also be held.
    assign stall_id  = load_use && !flush_ex;
    assign bubble_ex = load_use || flush_ex || !id_valid;

    assign rd_EX  = tag(vld_p0, wr_p0, rd_p0);
    assign rd_MEM = tag(vld_p1, wr_p1, rd_p1);
    assign rd_WB  = tag(vld_p2, wr_p2, rd_p2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            wr_p0  <= 1'b0;
            ld_p0  <= 1'b0;
            rd_p0  <= '0;
            vld_p1 <= 1'b0;
            wr_p1  <= 1'b0;
            rd_p1  <= '0;
            vld_p2 <= 1'b0;
            wr_p2  <= 1'b0;
            rd_p2  <= '0;
        end else begin
            // MEM -> WB, EX -> MEM: never stalled
            vld_p2 <= vld_p1;
            wr_p2  <= wr_p1;
            rd_p2  <= rd_p1;
            vld_p1 <= vld_p0;
            wr_p1  <= wr_p0;
            rd_p1  <= rd_p0;
            // ID -> EX
            if (bubble_ex) begin
                vld_p0 <= 1'b0;
                wr_p0  <= 1'b0;
                ld_p0  <= 1'b0;
                rd_p0  <= '0;
            end else begin
                vld_p0 <= 1'b1;
                wr_p0  <= id_reg_write;
                ld_p0  <= id_mem_read;
                rd_p0  <= id_rd;
            end
        end
    end

`ifdef RD_TRACKER_STALL_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall_id) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_rd_stage_tracker.sv
// Scoreboard bench for rd_stage_tracker: expected observations are queued as each
// stimulus vector is driven and popped when the outputs are sampled on the falling edge.
module tb_rd_stage_tracker;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;
`ifdef RD_TRACKER_STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       rst_n;
        logic       valid;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic [4:0] ex;
        logic [4:0] mem;
        logic [4:0] wb;
        logic       stall;
        logic       bubble;
        logic [1:0] cnt;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic              flush_ex;
    logic [REG_AW-1:0] rd_EX;
    logic [REG_AW-1:0] rd_MEM;
    logic [REG_AW-1:0] rd_WB;
    logic              stall_id;
    logic              bubble_ex;
    logic [CNT_W-1:0]  stall_count;

    int   vectors     = 0;
    int   miscompares = 0;
    obs_t exp_q[$];

    rd_stage_tracker #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .flush_ex(flush_ex), .rd_EX(rd_EX),
        .rd_MEM(rd_MEM), .rd_WB(rd_WB), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Writer instruction in ID (reg_write = 1); rn = 0 asserts reset alongside it.
    function automatic stim_t st(input logic [4:0] rd, input logic mr,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic fl, input logic rn);
        return '{rst_n: rn, valid: 1'b1, rd: rd, rw: 1'b1, mr: mr,
                 rs1: rs1, rs2: rs2, u1: u1, u2: u2, fl: fl};
    endfunction

    function automatic stim_t idle(input logic fl, input logic rn);
        return '{rst_n: rn, valid: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0,
                 rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, fl: fl};
    endfunction

    function automatic logic [1:0] ecnt(input int n);
        if (!CNT_EN) return 2'd0;
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    function automatic obs_t ob(input logic [4:0] ex, input logic [4:0] mem,
                                input logic [4:0] wb, input logic s, input logic b,
                                input logic [1:0] c);
        return '{ex: ex, mem: mem, wb: wb, stall: s, bubble: b, cnt: c};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ex=%0d mem=%0d wb=%0d stall=%0b bubble=%0b cnt=%0d",
                         o.ex, o.mem, o.wb, o.stall, o.bubble, o.cnt);
    endfunction

    task automatic apply(input stim_t s);
        rst_n        = s.rst_n;
        id_valid     = s.valid;
        id_rd        = s.rd;
        id_reg_write = s.rw;
        id_mem_read  = s.mr;
        id_rs1       = s.rs1;
        id_rs2       = s.rs2;
        id_uses_rs1  = s.u1;
        id_uses_rs2  = s.u2;
        flush_ex     = s.fl;
    endtask

    task automatic reset_cycle();
        apply(idle(1'b0, 1'b0));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        // First edge under reset from an unknown state is not observed.
        apply(st(5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        s.push_back(st(5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
        e.push_back(ob(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ecnt(0)));
        s.push_back(idle(1'b0, 1'b1));
        e.push_back(ob(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, ecnt(0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = '{rd_EX, rd_MEM, rd_WB, stall_id, bubble_ex, stall_count};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_pipeline();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        reset_cycle();
        s.push_back(st(5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
        e.push_back(ob(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ecnt(0)));
        s.push_back(idle(1'b0, 1'b1)); e.push_back(ob(5'd3, 5'd0, 5'd0, 1'b0, 1'b1, ecnt(0)));
        s.push_back(idle(1'b0, 1'b1)); e.push_back(ob(5'd0, 5'd3, 5'd0, 1'b0, 1'b1, ecnt(0)));
        s.push_back(idle(1'b0, 1'b1)); e.push_back(ob(5'd0, 5'd0, 5'd3, 1'b0, 1'b1, ecnt(0)));
        s.push_back(idle(1'b0, 1'b1)); e.push_back(ob(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, ecnt(0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = '{rd_EX, rd_MEM, rd_WB, stall_id, bubble_ex, stall_count};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL pipeline[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        reset_cycle();
        s.push_back(st(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
        e.push_back(ob(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ecnt(0)));
        s.push_back(st(5'd7, 1'b0, 5'd5, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1));
        e.push_back(ob(5'd5, 5'd0, 5'd0, 1'b1, 1'b1, ecnt(0)));
        s.push_back(st(5'd7, 1'b0, 5'd5, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1));
        e.push_back(ob(5'd0, 5'd5, 5'd0, 1'b0, 1'b0, ecnt(1)));
        s.push_back(idle(1'b0, 1'b1));
        e.push_back(ob(5'd7, 5'd0, 5'd5, 1'b0, 1'b1, ecnt(1)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = '{rd_EX, rd_MEM, rd_WB, stall_id, bubble_ex, stall_count};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL load_use[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_x0_nonuse();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        reset_cycle();
        s.push_back(st(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
        e.push_back(ob(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ecnt(0)));
        s.push_back(st(5'd8, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1));
        e.push_back(ob(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ecnt(0)));
        s.push_back(st(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
        e.push_back(ob(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, ecnt(0)));
        s.push_back(st(5'd9, 1'b0, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1));
        e.push_back(ob(5'd6, 5'd8, 5'd0, 1'b0, 1'b0, ecnt(0)));
        s.push_back(idle(1'b0, 1'b1));
        e.push_back(ob(5'd9, 5'd6, 5'd8, 1'b0, 1'b1, ecnt(0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = '{rd_EX, rd_MEM, rd_WB, stall_id, bubble_ex, stall_count};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL x0_nonuse[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        reset_cycle();
        s.push_back(st(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
        e.push_back(ob(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ecnt(0)));
        s.push_back(st(5'd7, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1));
        e.push_back(ob(5'd5, 5'd0, 5'd0, 1'b0, 1'b1, ecnt(0)));
        s.push_back(st(5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1));
        e.push_back(ob(5'd0, 5'd5, 5'd0, 1'b0, 1'b1, ecnt(0)));
        s.push_back(idle(1'b0, 1'b1));
        e.push_back(ob(5'd0, 5'd0, 5'd5, 1'b0, 1'b1, ecnt(0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = '{rd_EX, rd_MEM, rd_WB, stall_id, bubble_ex, stall_count};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL flush[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_counter();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        reset_cycle();
        // Each event: load x5, dependent x7 stalls once, then issues.
        for (int k = 0; k < 5; k++) begin
            s.push_back(st(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
            e.push_back(ob((k == 0) ? 5'd0 : 5'd7, 5'd0, (k == 0) ? 5'd0 : 5'd5,
                           1'b0, 1'b0, ecnt(k)));
            s.push_back(st(5'd7, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1));
            e.push_back(ob(5'd5, (k == 0) ? 5'd0 : 5'd7, 5'd0, 1'b1, 1'b1, ecnt(k)));
            s.push_back(st(5'd7, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1));
            e.push_back(ob(5'd0, 5'd5, (k == 0) ? 5'd0 : 5'd7, 1'b0, 1'b0, ecnt(k + 1)));
        end
        // Reset arriving mid-stall clears state and the counter without counting.
        s.push_back(st(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
        e.push_back(ob(5'd7, 5'd0, 5'd5, 1'b0, 1'b0, ecnt(5)));
        s.push_back(st(5'd7, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0));
        e.push_back(ob(5'd5, 5'd7, 5'd0, 1'b1, 1'b1, ecnt(5)));
        s.push_back(idle(1'b0, 1'b1));
        e.push_back(ob(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, ecnt(0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = '{rd_EX, rd_MEM, rd_WB, stall_id, bubble_ex, stall_count};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL counter[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        apply(idle(1'b0, 1'b0));
        #1;
        test_reset();
        test_pipeline();
        test_load_use();
        test_x0_nonuse();
        test_flush();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rd_stage_tracker.md
Name: rd_stage_tracker

Overview:
Producer side of the forwarding interface. It tracks the destination register of each in-flight instruction through the EX, MEM and WB stages, and drives the rd_EX / rd_MEM / rd_WB tags that the forwarding unit compares against rs1_d / rs2_d. It also detects load-use hazards the forwarding unit cannot cover, stalling ID and inserting an EX bubble. Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers in the 5-stage core.

Parameters:
REG_AW, 5, register address width (x0 is address 0)
CNT_W, 16, stall counter width (used only with the optional feature)

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rd  input  REG_AW  ID destination register
id_reg_write  input  1  ID instruction writes the register file
id_mem_read  input  1  ID instruction is a load
id_rs1  input  REG_AW  ID source 1
id_rs2  input  REG_AW  ID source 2
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
flush_ex  input  1  branch/jump redirect resolved in EX; kills the ID instruction
rd_EX  output  REG_AW  EX-stage destination tag; 0 = no writer
rd_MEM  output  REG_AW  MEM-stage destination tag; 0 = no writer
rd_WB  output  REG_AW  WB-stage destination tag; 0 = no writer
stall_id  output  1  hold PC and IF/ID this cycle
bubble_ex  output  1  ID/EX is loaded with a bubble on this edge
stall_count  output  CNT_W  stall cycle count (0 when the feature is disabled)

Behaviour:
- Per-stage state for EX, MEM and WB: {valid, rd, reg_write, mem_read}.
- Tag output: rd_X = (X.valid & X.reg_write & X.rd != 0) ? X.rd : 0. Outputs are registered-state decodes with no input-to-output path.
- Load-use condition (combinational): load_use = id_valid & EX.valid & EX.mem_read & EX.reg_write & EX.rd != 0 & ((id_uses_rs1 & id_rs1 == EX.rd) | (id_uses_rs2 & id_rs2 == EX.rd)).
- stall_id = load_use & ~flush_ex.
- bubble_ex = load_use | flush_ex | ~id_valid.
- Each edge, when rst_n = 1:
  - WB <= MEM and MEM <= EX. This always advances; the tracker never stalls MEM or WB.
  - If bubble_ex, EX <= all-zero; otherwise EX <= {1, id_rd, id_reg_write, id_mem_read}.
- Latency: a writer accepted in ID at edge n appears on rd_EX after edge n, rd_MEM after n+1, rd_WB after n+2, and clears after n+3 unless followed by another writer.
- Load-use stall lasts exactly one cycle. The next cycle EX holds a bubble, so load_use is 0 and the held instruction issues. The load is then in MEM, and the forwarding unit covers it from MEM.
- flush_ex and load_use in the same cycle: flush wins. stall_id = 0, EX gets a bubble, no stall is counted.
- Writers to x0 never produce a nonzero tag and never cause a stall.
- Reset (rst_n = 0 at an edge, including mid-stall): all stage state cleared. After that edge all tags = 0, stall_id = 0, bubble_ex = 1 while id_valid = 0, and stall_count = 0.

Optional Feature:
RD_TRACKER_STALL_COUNT_EN
- Defined: stall_count is a CNT_W-bit counter.
  - Increments on every edge where stall_id = 1.
  - Saturates at all-ones.
  - Cleared by synchronous reset.
- Undefined: no counter flops; stall_count is tied to 0.

Test Plan:
1. Reset: rst_n = 0 for 2 edges while id_valid = 1, id_rd = 3, id_reg_write = 1 -> rd_EX = rd_MEM = rd_WB = 0 and stall_id = 0 throughout.
2. Pipelining: one ALU writer with rd = 3 issued at edge 0, then id_valid = 0 -> rd_EX = 3 after edge 0, rd_MEM = 3 after edge 1, rd_WB = 3 after edge 2, all 0 after edge 3.
3. Load-use: load with rd = 5, then ID holds rs1 = 5, id_uses_rs1 = 1 -> stall_id = 1 and bubble_ex = 1 for exactly one cycle. Next cycle rd_EX = 0 and rd_MEM = 5; the held instruction enters EX on the following edge.
4. x0 and non-use: load with rd = 0 followed by rs1 = 0 -> no stall. Load with rd = 6 followed by rs2 = 6, id_uses_rs2 = 0 -> no stall.
5. Flush priority: load-use condition with flush_ex = 1 in the same cycle -> stall_id = 0, EX bubble, rd_MEM = load rd next cycle, stall_count unchanged.
6. Counter (macro defined, CNT_W = 2): 5 separate load-use events -> stall_count = 1, 2, 3, 3, 3. With the macro undefined -> stall_count stays 0.
